// File: rtl/tt_um_load_ctrl_if.sv
// tt_um_load_ctrl_if: handshake and status bundle between the load controller and its host.
interface tt_um_load_ctrl_if;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic       compute_req;
    logic       load_ena;
    logic [3:0] count;
    logic       row_valid;
    logic [2:0] row_idx;
    logic       busy;
    logic       load_done;
    logic       pass_done;
    logic       weights_loaded;
    modport master (
        output start, abort, in_valid, compute_req,
        input  in_ready, load_ena, count, row_valid, row_idx, busy, load_done, pass_done, weights_loaded
    );
    modport slave (
        input  start, abort, in_valid, compute_req,
        output in_ready, load_ena, count, row_valid, row_idx, busy, load_done, pass_done, weights_loaded
    );
endinterface

// File: rtl/tt_um_load_ctrl.sv
// tt_um_load_ctrl: sequences weight loads and compute passes for a rotating 28-bit row loader.
module tt_um_load_ctrl #(
    parameter int MAX_OUT_LEN = 7,
    parameter int LOAD_BEATS  = 14
) (
    input logic               clk,
    input logic               rst,
    tt_um_load_ctrl_if.slave  bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] READY     = 2'd2;
    localparam logic [1:0] COMPUTE   = 2'd3;
    localparam logic [2:0] ROT_LAST  = 3'(MAX_OUT_LEN - 1);
    localparam logic [3:0] BEAT_LAST = 4'(LOAD_BEATS - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] rot_q, rot_d;
    logic [2:0] pass_q, pass_d;
    logic [3:0] beat_q, beat_d;
    logic       wl_q, wl_d;
    logic       done_q, done_d;
    logic       accept;

    assign accept             = bus.in_valid && state_q == LOAD;
    assign bus.in_ready       = state_q == LOAD;
    assign bus.load_ena       = accept;
    assign bus.count          = state_q == LOAD ? beat_q : 4'd0;
    assign bus.row_valid      = state_q == COMPUTE;
    assign bus.row_idx        = rot_q;
    assign bus.busy           = state_q == LOAD || state_q == COMPUTE;
    assign bus.load_done      = done_q;
    assign bus.pass_done      = state_q == COMPUTE && pass_q == ROT_LAST;
    assign bus.weights_loaded = wl_q;

    // Next-state: rotation tracks the loader every cycle; abort beats a final beat, start beats compute_req.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wl_d    = wl_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        rot_d   = rot_q == ROT_LAST ? 3'd0 : rot_q + 3'd1;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = LOAD;
                beat_d  = 4'd0;
                wl_d    = 1'b0;
            end
            LOAD: if (bus.abort) begin
                state_d = IDLE;
                beat_d  = 4'd0;
                wl_d    = 1'b0;
            end else if (accept) begin
                state_d = beat_q == BEAT_LAST ? READY : LOAD;
                wl_d    = beat_q == BEAT_LAST;
                done_d  = beat_q == BEAT_LAST;
                beat_d  = beat_q == BEAT_LAST ? 4'd0 : beat_q + 4'd1;
            end
            READY: if (bus.start) begin
                state_d = LOAD;
                beat_d  = 4'd0;
                wl_d    = 1'b0;
            end else if (bus.compute_req) begin
                state_d = COMPUTE;
                pass_d  = 3'd0;
            end
            COMPUTE: begin
                state_d = pass_q == ROT_LAST ? READY : COMPUTE;
                pass_d  = pass_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset overriding every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rot_q   <= 3'd0;
            pass_q  <= 3'd0;
            beat_q  <= 4'd0;
            wl_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            pass_q  <= pass_d;
            beat_q  <= beat_d;
            wl_q    <= wl_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_tt_um_load_ctrl.sv
// tb_tt_um_load_ctrl: directed scoreboard bench for the load/compute controller.
module tb_tt_um_load_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tt_um_load_ctrl_if bus();
    tt_um_load_ctrl #(.MAX_OUT_LEN(7), .LOAD_BEATS(14)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    int exp_rot = 0;
    logic [3:0] q_cnt[$];
    logic [3:0] q_row[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic v, input logic c);
        logic [3:0] e;
        bus.start = s;
        bus.abort = a;
        bus.in_valid = v;
        bus.compute_req = c;
        @(negedge clk);
        chk("row_idx_rot", bus.row_idx, exp_rot);
        if (bus.load_ena) begin
            if (q_cnt.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL count_unexpected observed=%0d expected=none", bus.count);
            end else chk("count_sb", bus.count, q_cnt.pop_front());
        end
        if (bus.row_valid) begin
            if (q_row.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL row_unexpected observed=%0d expected=none", bus.row_idx);
            end else begin
                e = q_row.pop_front();
                chk("row_sb", bus.row_idx, e[2:0]);
                chk("pass_done_sb", bus.pass_done, e[3]);
            end
        end else chk("pass_done_idle", bus.pass_done, 0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        exp_rot = rst ? 0 : (exp_rot + 1) % 7;
    endtask

    task automatic push_rows();
        for (int i = 0; i < 7; i++) q_row.push_back({1'(i == 6), 3'((exp_rot + 1 + i) % 7)});
    endtask

    task automatic idle_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_load_ena"}, bus.load_ena, 0);
        chk({tag, "_count"}, bus.count, 0);
        chk({tag, "_row_valid"}, bus.row_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_load_done"}, bus.load_done, 0);
        chk({tag, "_pass_done"}, bus.pass_done, 0);
        chk({tag, "_wl"}, bus.weights_loaded, 0);
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.compute_req = 0;
        repeat (2) @(posedge clk);
        #1;
        exp_rot = 0;
        rst = 0;
        drive(0, 0, 0, 0); idle_zero("reset"); adv();
        drive(0, 0, 0, 1); adv();
        drive(0, 0, 0, 0); chk("idle_compute_busy", bus.busy, 0); adv();
        drive(1, 0, 0, 0); chk("idle_in_ready", bus.in_ready, 0); adv();
        for (int i = 0; i < 14; i++) begin
            q_cnt.push_back(4'(i));
            drive(i == 5, 0, 1, 0);
            chk("load_in_ready", bus.in_ready, 1);
            chk("load_ena", bus.load_ena, 1);
            chk("load_busy", bus.busy, 1);
            adv();
        end
        drive(0, 0, 0, 0);
        chk("load_done", bus.load_done, 1);
        chk("loaded", bus.weights_loaded, 1);
        chk("ready_in_ready", bus.in_ready, 0);
        chk("ready_busy", bus.busy, 0);
        adv();
        drive(0, 0, 0, 0); chk("load_done_pulse", bus.load_done, 0); adv();
        drive(0, 1, 0, 0); adv();
        drive(0, 0, 0, 0); chk("abort_ready_wl", bus.weights_loaded, 1); chk("abort_ready_ir", bus.in_ready, 0); adv();
        for (int k = 0; k < 8 && exp_rot != 4; k++) begin drive(0, 0, 0, 0); adv(); end
        push_rows();
        drive(0, 0, 0, 1); adv();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, i < 3);
            chk("cmp_row_valid", bus.row_valid, 1);
            chk("cmp_busy", bus.busy, 1);
            chk("cmp_wl", bus.weights_loaded, 1);
            adv();
        end
        drive(0, 0, 0, 0); chk("post_cmp_rv", bus.row_valid, 0); chk("post_cmp_busy", bus.busy, 0); adv();
        drive(1, 0, 0, 1); adv();
        drive(0, 0, 0, 0);
        chk("prio_in_ready", bus.in_ready, 1);
        chk("prio_rv", bus.row_valid, 0);
        chk("prio_wl", bus.weights_loaded, 0);
        adv();
        for (int k = 0; k < 27; k++) begin
            if (k % 2 == 0) q_cnt.push_back(4'(k / 2));
            drive(0, 0, k % 2 == 0, 0);
            chk("stall_ena", bus.load_ena, k % 2 == 0);
            chk("stall_count", bus.count, (k + 1) / 2);
            chk("stall_in_ready", bus.in_ready, 1);
            adv();
        end
        drive(0, 0, 0, 0); chk("stall_done", bus.load_done, 1); chk("stall_wl", bus.weights_loaded, 1); adv();
        drive(1, 0, 0, 0); adv();
        for (int i = 0; i < 6; i++) begin q_cnt.push_back(4'(i)); drive(0, 0, 1, 0); adv(); end
        q_cnt.push_back(4'd6);
        drive(0, 1, 1, 0); chk("abort_count", bus.count, 6); adv();
        drive(0, 0, 0, 0); idle_zero("abort"); adv();
        drive(1, 0, 0, 0); adv();
        for (int i = 0; i < 13; i++) begin
            q_cnt.push_back(4'(i));
            drive(0, 0, 1, 0);
            if (i == 0) chk("restart_in_ready", bus.in_ready, 1);
            adv();
        end
        q_cnt.push_back(4'd13);
        drive(0, 1, 1, 0); adv();
        drive(0, 0, 0, 0); idle_zero("abort_last"); adv();
        drive(1, 0, 0, 0); adv();
        for (int i = 0; i < 14; i++) begin q_cnt.push_back(4'(i)); drive(0, 0, 1, 0); adv(); end
        drive(0, 0, 0, 0); chk("reload_done", bus.load_done, 1); adv();
        push_rows();
        drive(0, 0, 0, 1); adv();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1;
            drive(0, 0, 0, 0);
            chk("rst_cmp_rv", bus.row_valid, 1);
            adv();
        end
        rst = 0;
        q_row.delete();
        drive(0, 0, 0, 0); idle_zero("rst_cmp"); chk("rst_cmp_rot", bus.row_idx, 0); adv();
        drive(0, 0, 0, 0);
        chk("sb_drained", q_cnt.size() + q_row.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
